// File: rtl/div_sqrt_seq_mvp.sv
// Sequencing FSM for an iterative FP divide/square-root datapath: accepts a request,
// derives the iteration count from format/precision/radix, and strobes start/iterate/round.
module div_sqrt_seq_mvp #(
   parameter int ITER_CNT_W = 6
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RBI,
   input  logic                  In_valid_SI,
   output logic                  In_ready_SO,
   input  logic                  Op_SI,
   input  logic [1:0]            Format_sel_SI,
   input  logic [5:0]            Precision_ctl_SI,
   input  logic [1:0]            Iter_unit_num_SI,
   input  logic                  Kill_SI,
   output logic                  Start_SO,
   output logic                  Iter_en_SO,
   output logic [ITER_CNT_W-1:0] Iter_cnt_DO,
   output logic                  Final_SO,
   output logic                  Round_en_SO,
   output logic                  Op_SO,
   output logic [1:0]            Format_DO,
   output logic                  Out_valid_SO,
   input  logic                  Out_ready_SI
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ITER  = 3'd2,
      ROUND = 3'd3,
      HOLD  = 3'd4
   } state_e;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [ITER_CNT_W-1:0] r_cnt;
   logic [ITER_CNT_W-1:0] w_cnt_nxt;
   logic [ITER_CNT_W-1:0] w_cnt_load;
   logic                  r_op;
   logic [1:0]            r_fmt;
   logic [5:0]            r_prec;
   logic [1:0]            r_iu;

   logic                  w_accept;
   logic                  w_ready;
   logic                  w_start;
   logic                  w_iter_en;
   logic                  w_final;
   logic                  w_round;
   logic                  w_valid;

   logic [6:0]            w_mant;
   logic [6:0]            w_prec;
   logic [6:0]            w_prec_clip;
   logic [6:0]            w_q;
   logic [6:0]            w_n;

   // Quotient length and iteration count, derived from the latched request only.
   always_comb begin
      case (r_fmt)
         2'b00:   w_mant = 7'd23;
         2'b01:   w_mant = 7'd52;
         2'b10:   w_mant = 7'd10;
         default: w_mant = 7'd7;
      endcase
   end

   assign w_prec      = {1'b0, r_prec};
   assign w_prec_clip = (w_prec < (w_mant + 7'd1)) ? w_prec : (w_mant + 7'd1);
   assign w_q         = (r_prec == 6'd0) ? (w_mant + 7'd3) : (w_prec_clip + 7'd2);

   always_comb begin
      case (r_iu)
         2'd0:    w_n = w_q;
         2'd1:    w_n = (w_q + 7'd1) >> 1;
         2'd2:    w_n = (w_q + 7'd2) / 7'd3;
         default: w_n = (w_q + 7'd3) >> 2;
      endcase
   end

   // Q is at least 3, so N is at least 1 and N-1 never underflows.
   assign w_cnt_load = ITER_CNT_W'(w_n - 7'd1);

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_ready     = 1'b0;
      w_start     = 1'b0;
      w_iter_en   = 1'b0;
      w_final     = 1'b0;
      w_round     = 1'b0;
      w_valid     = 1'b0;

      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (In_valid_SI && !Kill_SI) begin
               w_accept    = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_start     = 1'b1;
            w_cnt_nxt   = w_cnt_load;
            w_state_nxt = ITER;
         end
         ITER: begin
            w_iter_en = 1'b1;
            if (r_cnt == '0) begin
               w_final     = 1'b1;
               w_state_nxt = ROUND;
            end else begin
               w_cnt_nxt = r_cnt - ITER_CNT_W'(1);
            end
         end
         ROUND: begin
            w_round     = 1'b1;
            w_state_nxt = HOLD;
         end
         HOLD: begin
            w_valid = 1'b1;
            if (Out_ready_SI) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Kill aborts in the same cycle: no strobe escapes, and a HOLD handshake is not honoured.
      if (Kill_SI && (r_state != IDLE)) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_start     = 1'b0;
         w_iter_en   = 1'b0;
         w_final     = 1'b0;
         w_round     = 1'b0;
         w_valid     = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= 1'b0;
         r_fmt   <= 2'b00;
         r_prec  <= 6'd0;
         r_iu    <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_op   <= Op_SI;
            r_fmt  <= Format_sel_SI;
            r_prec <= Precision_ctl_SI;
            r_iu   <= Iter_unit_num_SI;
         end
      end
   end

   // Outputs are forced low while reset is held, before the reset edge has cleared the state.
   assign In_ready_SO  = Rst_RBI & w_ready;
   assign Start_SO     = Rst_RBI & w_start;
   assign Iter_en_SO   = Rst_RBI & w_iter_en;
   assign Final_SO     = Rst_RBI & w_final;
   assign Round_en_SO  = Rst_RBI & w_round;
   assign Out_valid_SO = Rst_RBI & w_valid;
   assign Op_SO        = Rst_RBI & r_op;
   assign Format_DO    = Rst_RBI ? r_fmt : 2'b00;
   assign Iter_cnt_DO  = Rst_RBI ? r_cnt : '0;

endmodule

// File: tb/tb_div_sqrt_seq_mvp.sv
// Directed bench for div_sqrt_seq_mvp: table of format/precision/radix vectors with
// hand-computed iteration counts, plus kill, reset and back-pressure sequences.
module tb_div_sqrt_seq_mvp;

   logic       Clk_CI;
   logic       Rst_RBI;
   logic       In_valid_SI;
   logic       In_ready_SO;
   logic       Op_SI;
   logic [1:0] Format_sel_SI;
   logic [5:0] Precision_ctl_SI;
   logic [1:0] Iter_unit_num_SI;
   logic       Kill_SI;
   logic       Start_SO;
   logic       Iter_en_SO;
   logic [5:0] Iter_cnt_DO;
   logic       Final_SO;
   logic       Round_en_SO;
   logic       Op_SO;
   logic [1:0] Format_DO;
   logic       Out_valid_SO;
   logic       Out_ready_SI;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       op;
      logic [1:0] fmt;
      logic [5:0] prec;
      logic [1:0] iu;
      int         n;
   } vec_t;

   vec_t vecs [10];

   div_sqrt_seq_mvp #(.ITER_CNT_W(6)) dut (
      .Clk_CI           (Clk_CI),
      .Rst_RBI          (Rst_RBI),
      .In_valid_SI      (In_valid_SI),
      .In_ready_SO      (In_ready_SO),
      .Op_SI            (Op_SI),
      .Format_sel_SI    (Format_sel_SI),
      .Precision_ctl_SI (Precision_ctl_SI),
      .Iter_unit_num_SI (Iter_unit_num_SI),
      .Kill_SI          (Kill_SI),
      .Start_SO         (Start_SO),
      .Iter_en_SO       (Iter_en_SO),
      .Iter_cnt_DO      (Iter_cnt_DO),
      .Final_SO         (Final_SO),
      .Round_en_SO      (Round_en_SO),
      .Op_SO            (Op_SO),
      .Format_DO        (Format_DO),
      .Out_valid_SO     (Out_valid_SO),
      .Out_ready_SI     (Out_ready_SI)
   );

   initial Clk_CI = 1'b0;
   always #5 Clk_CI = ~Clk_CI;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are driven 2 time units after the edge and outputs sampled 1 unit later.
   task automatic step();
      @(posedge Clk_CI);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, 64'({In_ready_SO, Start_SO, Iter_en_SO, Iter_cnt_DO, Final_SO,
                       Round_en_SO, Op_SO, Format_DO, Out_valid_SO}), 64'(0));
   endtask

   // Presents a request in the current cycle and advances into START.
   task automatic accept(input logic op, input logic [1:0] fmt, input logic [5:0] prec,
                         input logic [1:0] iu);
      In_valid_SI      = 1'b1;
      Op_SI            = op;
      Format_sel_SI    = fmt;
      Precision_ctl_SI = prec;
      Iter_unit_num_SI = iu;
      settle();
      check("accept_ready", 64'(In_ready_SO), 64'(1));
      step();
      In_valid_SI      = 1'b0;
      Op_SI            = ~op;
      Format_sel_SI    = ~fmt;
      Precision_ctl_SI = 6'd0;
      Iter_unit_num_SI = 2'd0;
      settle();
      check("start_strobe", 64'(Start_SO), 64'(1));
      check("start_not_ready", 64'(In_ready_SO), 64'(0));
      check("start_no_iter", 64'(Iter_en_SO), 64'(0));
   endtask

   task automatic run_op(input logic op, input logic [1:0] fmt, input logic [5:0] prec,
                         input logic [1:0] iu, input int n, input int hold);
      accept(op, fmt, prec, iu);
      for (int k = 0; k < n; k++) begin
         step();
         settle();
         check("iter_en", 64'(Iter_en_SO), 64'(1));
         check("iter_cnt", 64'(Iter_cnt_DO), 64'(n - 1 - k));
         check("iter_final", 64'(Final_SO), 64'(k == n - 1));
         check("iter_onehot", 64'({Start_SO, Round_en_SO, Out_valid_SO}), 64'(0));
      end
      step();
      settle();
      check("round_en", 64'(Round_en_SO), 64'(1));
      check("round_no_iter", 64'(Iter_en_SO), 64'(0));
      check("round_no_valid", 64'(Out_valid_SO), 64'(0));
      for (int h = 0; h <= hold; h++) begin
         step();
         Out_ready_SI = (h == hold);
         settle();
         check("hold_valid", 64'(Out_valid_SO), 64'(1));
         check("hold_op", 64'(Op_SO), 64'(op));
         check("hold_fmt", 64'(Format_DO), 64'(fmt));
         check("hold_not_ready", 64'(In_ready_SO), 64'(0));
      end
      step();
      Out_ready_SI = 1'b0;
      settle();
      check("retire_ready", 64'(In_ready_SO), 64'(1));
      check("retire_no_valid", 64'(Out_valid_SO), 64'(0));
   endtask

   initial begin
      // op, fmt, prec, iu, N = ceil(Q/B)
      vecs[0] = '{1'b0, 2'b00, 6'd0,  2'd2, 9};   // FP32 Q=26 B=3
      vecs[1] = '{1'b1, 2'b01, 6'd0,  2'd3, 14};  // FP64 Q=55 B=4
      vecs[2] = '{1'b0, 2'b11, 6'd0,  2'd0, 10};  // FP16alt Q=10 B=1
      vecs[3] = '{1'b1, 2'b01, 6'd10, 2'd1, 6};   // FP64 Q=12 B=2
      vecs[4] = '{1'b0, 2'b10, 6'd0,  2'd1, 7};   // FP16 Q=13 B=2
      vecs[5] = '{1'b1, 2'b00, 6'd30, 2'd0, 26};  // FP32 prec clipped to 24, Q=26
      vecs[6] = '{1'b0, 2'b01, 6'd63, 2'd0, 55};  // FP64 prec clipped to 53, Q=55 (max N)
      vecs[7] = '{1'b1, 2'b11, 6'd1,  2'd3, 1};   // FP16alt Q=3 B=4 (min N)
      vecs[8] = '{1'b0, 2'b10, 6'd5,  2'd2, 3};   // FP16 Q=7 B=3
      vecs[9] = '{1'b1, 2'b00, 6'd0,  2'd3, 7};   // FP32 Q=26 B=4

      Rst_RBI          = 1'b0;
      In_valid_SI      = 1'b1;
      Op_SI            = 1'b1;
      Format_sel_SI    = 2'b01;
      Precision_ctl_SI = 6'd0;
      Iter_unit_num_SI = 2'd0;
      Kill_SI          = 1'b0;
      Out_ready_SI     = 1'b1;

      step();
      step();
      settle();
      check_all_zero("reset_outputs");
      In_valid_SI  = 1'b0;
      Out_ready_SI = 1'b0;
      Rst_RBI      = 1'b1;
      settle();
      check("post_reset_ready", 64'(In_ready_SO), 64'(1));
      step();
      settle();
      check("post_reset_idle_ready", 64'(In_ready_SO), 64'(1));
      check("post_reset_no_start", 64'(Start_SO), 64'(0));

      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].fmt, vecs[i].prec, vecs[i].iu, vecs[i].n, 0);
      end

      // Back-pressure: result held five cycles, retired on the sixth.
      run_op(1'b1, 2'b01, 6'd10, 2'd1, 6, 5);

      // Kill in the third ITER cycle.
      accept(1'b0, 2'b00, 6'd0, 2'd2);
      step();
      step();
      step();
      Kill_SI = 1'b1;
      settle();
      check("kill_iter_no_round", 64'(Round_en_SO), 64'(0));
      step();
      Kill_SI = 1'b0;
      settle();
      check("kill_iter_idle", 64'(In_ready_SO), 64'(1));
      check("kill_iter_quiet", 64'({Start_SO, Iter_en_SO, Round_en_SO, Out_valid_SO}), 64'(0));
      for (int c = 0; c < 12; c++) begin
         step();
         settle();
         check("kill_iter_stays_quiet", 64'({Iter_en_SO, Round_en_SO, Out_valid_SO}), 64'(0));
      end
      run_op(1'b1, 2'b11, 6'd0, 2'd0, 10, 0);

      // Kill with a request in IDLE: no acceptance.
      Kill_SI     = 1'b1;
      In_valid_SI = 1'b1;
      settle();
      check("kill_idle_ready", 64'(In_ready_SO), 64'(1));
      step();
      Kill_SI     = 1'b0;
      In_valid_SI = 1'b0;
      settle();
      check("kill_idle_no_start", 64'(Start_SO), 64'(0));
      check("kill_idle_still_ready", 64'(In_ready_SO), 64'(1));

      // Kill in HOLD together with Out_ready: result dropped.
      accept(1'b1, 2'b11, 6'd1, 2'd3);
      step();
      step();
      step();
      settle();
      check("kill_hold_valid_before", 64'(Out_valid_SO), 64'(1));
      Kill_SI      = 1'b1;
      Out_ready_SI = 1'b1;
      step();
      Kill_SI      = 1'b0;
      Out_ready_SI = 1'b0;
      settle();
      check("kill_hold_idle", 64'(In_ready_SO), 64'(1));
      check("kill_hold_no_valid", 64'(Out_valid_SO), 64'(0));

      // Reset asserted during ITER.
      accept(1'b1, 2'b01, 6'd0, 2'd3);
      step();
      step();
      Rst_RBI = 1'b0;
      step();
      settle();
      check_all_zero("reset_mid_iter");
      Rst_RBI = 1'b1;
      settle();
      check("reset_mid_ready", 64'(In_ready_SO), 64'(1));
      for (int c = 0; c < 20; c++) begin
         step();
         settle();
         check("reset_mid_no_stale", 64'({Start_SO, Iter_en_SO, Round_en_SO, Out_valid_SO}), 64'(0));
      end
      run_op(1'b0, 2'b00, 6'd0, 2'd2, 9, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_sqrt_seq_mvp.md
DIV_SQRT_SEQ_MVP -- requirements
Module: div_sqrt_seq_mvp

Interface
REQ-001 SHALL have parameter ITER_CNT_W, default 6; width of the iteration counter.
REQ-002 SHALL have port Clk_CI, input, 1; single clock, rising-edge.
REQ-003 SHALL have port Rst_RBI, input, 1; reset, synchronous, active-low.
REQ-004 SHALL have port In_valid_SI, input, 1; operation request.
REQ-005 SHALL have port In_ready_SO, output, 1; request accepted when In_valid_SI & In_ready_SO.
REQ-006 SHALL have port Op_SI, input, 1; 0=div, 1=sqrt.
REQ-007 SHALL have port Format_sel_SI, input, 2; 00 FP32, 01 FP64, 10 FP16, 11 FP16alt.
REQ-008 SHALL have port Precision_ctl_SI, input, 6; 0=full precision, else requested mantissa bits.
REQ-009 SHALL have port Iter_unit_num_SI, input, 2; bits per iteration cycle B = value+1.
REQ-010 SHALL have port Kill_SI, input, 1; abort current operation.
REQ-011 SHALL have port Start_SO, output, 1; one-cycle datapath load/start strobe.
REQ-012 SHALL have port Iter_en_SO, output, 1; datapath iteration enable.
REQ-013 SHALL have port Iter_cnt_DO, output, ITER_CNT_W; remaining iterations, counting down.
REQ-014 SHALL have port Final_SO, output, 1; last iteration cycle.
REQ-015 SHALL have port Round_en_SO, output, 1; one-cycle rounding/normalisation strobe.
REQ-016 SHALL have ports Op_SO (1), Format_DO (2), outputs; latched Op_SI/Format_sel_SI of the accepted operation.
REQ-017 SHALL have port Out_valid_SO, output, 1; result valid.
REQ-018 SHALL have port Out_ready_SI, input, 1; result consumed when Out_valid_SO & Out_ready_SI.

Function
REQ-019 SHALL implement FSM states IDLE, START, ITER, ROUND, HOLD.
REQ-020 In_ready_SO SHALL be 1 only in IDLE; no acceptance in any other state.
REQ-021 On accept, SHALL latch Op, Format, Precision, B and go to START.
REQ-022 Mantissa width M SHALL be 23/52/10/7 for FP32/FP64/FP16/FP16alt.
REQ-023 Quotient bits Q SHALL be M+3 if precision is 0, else min(precision, M+1)+2.
REQ-024 Iteration count N SHALL be ceil(Q/B), computed combinationally from latched values; same N for div and sqrt.
REQ-025 START SHALL last exactly one cycle with Start_SO=1, Iter_cnt_DO loaded with N-1, then go to ITER.
REQ-026 ITER SHALL assert Iter_en_SO every cycle, decrement Iter_cnt_DO, and assert Final_SO when Iter_cnt_DO==0; next state ROUND.
REQ-027 ROUND SHALL last one cycle with Round_en_SO=1, then go to HOLD.
REQ-028 HOLD SHALL assert Out_valid_SO until Out_ready_SI; on handshake go to IDLE.
REQ-029 Latency: accept at cycle t gives Start_SO at t+1, ITER at t+2..t+1+N, Round_en_SO at t+2+N, Out_valid_SO first at t+3+N.
REQ-030 Out_valid_SO SHALL remain high, and Op_SO/Format_DO stable, while Out_ready_SI=0.
REQ-031 Kill_SI in any non-IDLE state SHALL force IDLE next cycle with no Out_valid_SO, Round_en_SO or further Iter_en_SO.
REQ-032 Kill_SI together with In_valid_SI in IDLE: kill wins, no acceptance, In_ready_SO stays 1.
REQ-033 Kill_SI in HOLD together with Out_ready_SI SHALL be treated as kill; result is dropped.
REQ-034 Start_SO, Iter_en_SO, Round_en_SO, Out_valid_SO SHALL be one-hot or all zero in every cycle.
REQ-035 Counter SHALL never wrap below 0; N ≤ 2^ITER_CNT_W holds for all legal inputs (max N=55).

Reset
REQ-036 While Rst_RBI=0 at a clock edge, SHALL enter IDLE and clear the counter and all latched fields.
REQ-037 All outputs SHALL be 0 during reset, including In_ready_SO; In_ready_SO goes to 1 in the first cycle after reset release.
REQ-038 Reset mid-operation SHALL abandon the operation silently; no Out_valid_SO follows.

Verification
REQ-039 FP32, precision 0, Iter_unit_num 2 (B=3): Q=26, N=9 -> Start_SO at t+1, 9 Iter_en_SO cycles, Out_valid_SO at t+12.
REQ-040 FP64, precision 0, Iter_unit_num 3: N=14, Iter_cnt_DO goes 13..0, Final_SO only when 0; FP16alt, Iter_unit_num 0: N=10.
REQ-041 FP64, precision 10, Iter_unit_num 1: Q=12, N=6 -> Out_valid_SO at t+9.
REQ-042 Out_ready_SI held 0 for 5 cycles in HOLD -> Out_valid_SO stays 1 with stable Op_SO/Format_DO; retire on cycle 6; In_ready_SO=1 next cycle.
REQ-043 Kill_SI in 3rd ITER cycle -> IDLE next cycle, no Round_en_SO/Out_valid_SO; new request accepted normally afterwards.
REQ-044 Rst_RBI=0 during ITER -> all outputs 0 next edge; after release, In_ready_SO=1 and no stale Out_valid_SO.
